serial_mac_fir: RTL and testbench

Time-multiplexed, parametrised FIR filter that replaces the fully parallel 27-tap FIR.
- Uses one signed multiplier-accumulator, iterated TAPS times per input sample.
- Coefficients are held in a run-time writable register bank, not hard-wired constants.
- Sits between the sample source and the downstream DSP chain, with valid/ready input, valid-only output, and rounded, saturated output.

---
 rtl/serial_mac_fir.sv | 165 ++++++++++++++++
 tb/tb_serial_mac_fir.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mac_fir.sv
// serial_mac_fir
// Time-multiplexed FIR filter: a single signed multiply-accumulate is iterated
// TAPS times per accepted input sample. Coefficients live in a run-time
// writable register bank; the output is rounded (half up), arithmetically
// shifted by SHIFT and saturated to OUT_W bits.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (clears coefficients too)
//   in_data    signed input sample            in_valid  sample present
//   in_ready   block can accept a sample (registered, low while in reset)
//   coef_we    coefficient write strobe (honoured only while idle)
//   coef_addr  coefficient index               coef_wdata signed coefficient
//   out_data   signed filtered sample          out_valid one-cycle strobe
//   out_sat    out_data was clipped (qualified by out_valid, held between)
//   busy       a MAC sequence is in progress
module serial_mac_fir #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 27,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int ADDR_W = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic        [ADDR_W-1:0] coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int BIAS_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic        [ACC_W:0] ONE      = (ACC_W + 1)'(1);
  localparam logic signed [ACC_W:0] RND_BIAS = (SHIFT > 0) ? signed'(ONE << BIAS_SH) : '0;
  // Output limits expressed at accumulator width (+1 guard bit) for comparison.
  localparam logic signed [ACC_W:0] OUT_MAX  = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN  = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic        [ADDR_W-1:0] LAST  = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state_reg;
  logic signed [COEF_W-1:0]  coef_reg  [TAPS];
  logic signed [DATA_W-1:0]  dline_reg [TAPS];
  logic        [ADDR_W-1:0]  wp_reg;
  logic        [ADDR_W-1:0]  rp_reg;     // walks backwards through history: x[n-k]
  logic        [ADDR_W-1:0]  k_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic                      in_ready_reg;
  logic                      busy_reg;
  logic                      out_valid_reg;
  logic                      out_sat_reg;
  logic signed [OUT_W-1:0]   out_data_reg;

  logic                      accept;
  logic                      coef_wr;
  logic        [ADDR_W-1:0]  wp_next;
  logic        [ADDR_W-1:0]  rp_next;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W:0]     rnd_sum;
  logic signed [ACC_W:0]     shifted;
  logic signed [OUT_W-1:0]   sat_data;
  logic                      sat_flag;

  assign accept  = in_valid & in_ready_reg;
  assign coef_wr = coef_we && (state_reg == IDLE) && (coef_addr <= LAST);
  assign wp_next = (wp_reg == LAST) ? '0 : wp_reg + ADDR_W'(1);
  assign rp_next = (rp_reg == '0) ? LAST : rp_reg - ADDR_W'(1);

  assign prod     = coef_reg[k_reg] * dline_reg[rp_reg];
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // One guard bit keeps the rounding bias from overflowing the accumulator range.
  assign rnd_sum = {acc_reg[ACC_W-1], acc_reg} + RND_BIAS;
  assign shifted = rnd_sum >>> SHIFT;

  always_comb begin
    sat_data = shifted[OUT_W-1:0];
    sat_flag = 1'b0;
    if (shifted > OUT_MAX) begin
      sat_data = OUT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (shifted < OUT_MIN) begin
      sat_data = OUT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      wp_reg        <= '0;
      rp_reg        <= '0;
      k_reg         <= '0;
      acc_reg       <= '0;
      in_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sat_reg   <= 1'b0;
      out_data_reg  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef_reg[i]  <= '0;
        dline_reg[i] <= '0;
      end
    end else begin
      // A write coincident with an accept lands before the first MAC step reads it.
      if (coef_wr) begin
        coef_reg[coef_addr] <= coef_wdata;
      end
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            dline_reg[wp_next] <= in_data;
            wp_reg       <= wp_next;
            rp_reg       <= wp_next;
            acc_reg      <= '0;
            k_reg        <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= MAC;
          end else begin
            in_ready_reg <= 1'b1;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + prod_ext;
          k_reg   <= k_reg + ADDR_W'(1);
          rp_reg  <= rp_next;
          if (k_reg == LAST) begin
            state_reg <= OUT;
          end
        end
        OUT: begin
          out_data_reg  <= sat_data;
          out_sat_reg   <= sat_flag;
          out_valid_reg <= 1'b1;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign busy      = busy_reg;
  assign out_valid = out_valid_reg;
  assign out_sat   = out_sat_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_serial_mac_fir.sv
// Bench for serial_mac_fir: two instances share one stimulus stream, one with
// SHIFT=0/OUT_W=40 (raw accumulator visible) and one with default parameters.
// A sample-level FIR model predicts every output; directed vectors pin it.
module tb_serial_mac_fir;
  localparam int TAPS = 27;
  localparam int AW   = $clog2(TAPS);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [15:0] in_data = '0;
  logic in_valid = 1'b0;
  logic coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic signed [15:0] coef_wdata = '0;

  logic in_ready0, out_valid0, out_sat0, busy0;
  logic signed [39:0] out_data0;
  logic in_ready1, out_valid1, out_sat1, busy1;
  logic signed [15:0] out_data1;

  serial_mac_fir #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .ACC_W(40), .OUT_W(40), .SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_data(out_data0), .out_valid(out_valid0), .out_sat(out_sat0), .busy(busy0));

  serial_mac_fir dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_data(out_data1), .out_valid(out_valid1), .out_sat(out_sat1), .busy(busy1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  longint ecount = 0;
  longint ready_edge = 0;
  longint idle_edge = 0;
  longint last_acc = -1000;
  bit     have_acc = 1'b0;
  longint coef_m [TAPS];
  longint hist   [TAPS];
  typedef struct {
    longint due;
    longint d0;
    bit     s0;
    longint d1;
    bit     s1;
  } exp_t;
  exp_t   expq[$];
  longint acc_edges[$];
  longint log0[$];
  longint log1[$];
  longint slog1[$];
  longint last_d0 = 0, last_d1 = 0;
  bit     last_s0 = 1'b0, last_s1 = 1'b0;
  int     n_out = 0;

  function automatic void chk(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: actual %0d, expected %0d (edge %0d)", name, act, exp_v, ecount);
    end
  endfunction

  function automatic void round_sat(input longint acc, input int shift, input int outw,
                                    output longint r, output bit sat);
    longint mx, mn;
    if (shift > 0) r = (acc + (longint'(1) <<< (shift - 1))) >>> shift;
    else r = acc;
    mx = (longint'(1) <<< (outw - 1)) - 1;
    mn = -(longint'(1) <<< (outw - 1));
    sat = 1'b0;
    if (r > mx) begin
      r = mx; sat = 1'b1;
    end else if (r < mn) begin
      r = mn; sat = 1'b1;
    end
  endfunction

  // Model: observes inputs at every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      ecount++;
      if (!reset) begin
        for (int i = 0; i < TAPS; i++) begin
          coef_m[i] = 0;
          hist[i] = 0;
        end
        expq.delete();
        have_acc   = 1'b0;
        idle_edge  = ecount + 1;
        ready_edge = ecount + 2;
      end else begin
        if (coef_we && int'(coef_addr) < TAPS && ecount >= idle_edge)
          coef_m[int'(coef_addr)] = longint'(coef_wdata);
        if (in_valid && ecount >= ready_edge) begin
          exp_t e;
          longint y;
          for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = longint'(in_data);
          y = 0;
          for (int k = 0; k < TAPS; k++) y += coef_m[k] * hist[k];
          e.due = ecount + TAPS + 1;
          round_sat(y, 0, 40, e.d0, e.s0);
          round_sat(y, 15, 16, e.d1, e.s1);
          expq.push_back(e);
          acc_edges.push_back(ecount);
          last_acc   = ecount;
          have_acc   = 1'b1;
          ready_edge = ecount + TAPS + 2;
          idle_edge  = ecount + TAPS + 2;
        end
      end
    end
  end

  // Compare: every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_in_ready0", longint'(in_ready0), 0);
        chk("rst_in_ready1", longint'(in_ready1), 0);
        chk("rst_out_valid0", longint'(out_valid0), 0);
        chk("rst_out_valid1", longint'(out_valid1), 0);
        chk("rst_busy0", longint'(busy0), 0);
        chk("rst_busy1", longint'(busy1), 0);
        chk("rst_out_data0", longint'(out_data0), 0);
        chk("rst_out_data1", longint'(out_data1), 0);
        chk("rst_out_sat1", longint'(out_sat1), 0);
        last_d0 = 0; last_d1 = 0; last_s0 = 1'b0; last_s1 = 1'b0;
      end else begin
        bit exp_ready, exp_busy, exp_valid;
        exp_ready = (ecount + 1 >= ready_edge);
        exp_busy  = have_acc && (ecount >= last_acc) && (ecount < last_acc + TAPS + 1);
        exp_valid = (expq.size() > 0) && (expq[0].due == ecount);
        chk("in_ready0", longint'(in_ready0), longint'(exp_ready));
        chk("in_ready1", longint'(in_ready1), longint'(exp_ready));
        chk("busy0", longint'(busy0), longint'(exp_busy));
        chk("busy1", longint'(busy1), longint'(exp_busy));
        chk("out_valid0", longint'(out_valid0), longint'(exp_valid));
        chk("out_valid1", longint'(out_valid1), longint'(exp_valid));
        if (exp_valid) begin
          exp_t e;
          e = expq.pop_front();
          last_d0 = e.d0; last_s0 = e.s0;
          last_d1 = e.d1; last_s1 = e.s1;
          n_out++;
          $display("out %0d edge %0d: dut0=%0d sat=%0d dut1=%0d sat=%0d", n_out, ecount,
                   longint'(out_data0), out_sat0, longint'(out_data1), out_sat1);
        end
        chk("out_data0", longint'(out_data0), last_d0);
        chk("out_sat0", longint'(out_sat0), longint'(last_s0));
        chk("out_data1", longint'(out_data1), last_d1);
        chk("out_sat1", longint'(out_sat1), longint'(last_s1));
        if (out_valid0) log0.push_back(longint'(out_data0));
        if (out_valid1) begin
          log1.push_back(longint'(out_data1));
          slog1.push_back(longint'(out_sat1));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_coef(input int a, input longint v);
    coef_we = 1'b1;
    coef_addr = AW'(a);
    coef_wdata = 16'(v);
    tick(1);
    coef_we = 1'b0;
  endtask

  // Presents a sample until accepted; optionally holds a coefficient write
  // alongside it so the write coincides with the accept edge.
  task automatic send_w(input longint x, input bit wr, input int a, input longint v);
    int n;
    in_valid = 1'b1;
    in_data = 16'(x);
    if (wr) begin
      coef_we = 1'b1;
      coef_addr = AW'(a);
      coef_wdata = 16'(v);
    end
    n = 0;
    while (1) begin
      tick(1);
      if (last_acc == ecount) break;
      n++;
      if (n > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: sample %0d not accepted within 200 cycles", x);
        break;
      end
    end
    in_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic send(input longint x);
    send_w(x, 1'b0, 0, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    if (expq.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d outputs still pending", expq.size());
    end
    tick(2);
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    slog1.delete();
    acc_edges.delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    tick(n);
    reset = 1'b1;
    tick(2);
  endtask

  initial begin
    #1;
    do_reset(3);

    // Impulse response with coef[k]=k+1, input held valid continuously.
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    clear_logs();
    send(1);
    repeat (TAPS - 1) send(0);
    drain();
    chk("impulse_count", log0.size(), TAPS);
    for (int i = 0; i < TAPS && i < log0.size(); i++) chk("impulse_dut0", log0[i], i + 1);
    for (int i = 0; i < TAPS && i < log1.size(); i++) chk("impulse_dut1", log1[i], 0);
    for (int i = 1; i < acc_edges.size(); i++)
      chk("accept_spacing", acc_edges[i] - acc_edges[i-1], TAPS + 2);

    // Dropped writes (out of range while idle, any write during MAC) and a
    // write coincident with an accept.
    clear_logs();
    write_coef(31, 5);
    send(1);
    write_coef(0, 99);
    send_w(0, 1'b1, 1, 7);
    send(0);
    drain();
    chk("coefw_count", log0.size(), 3);
    if (log0.size() == 3) begin
      chk("coefw_mac_drop", log0[0], 1);
      chk("coefw_coincident", log0[1], 7);
      chk("coefw_tap2", log0[2], 3);
    end

    // Ramp with 0.5 coefficients and constant input 1000.
    do_reset(2);
    for (int k = 0; k < TAPS; k++) write_coef(k, 16384);
    clear_logs();
    repeat (30) send(1000);
    drain();
    chk("ramp_count", log1.size(), 30);
    for (int i = 0; i < log1.size(); i++)
      chk("ramp_dut1", log1[i], (i < TAPS) ? (i + 1) * 500 : 13500);

    // Saturation in both directions.
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    clear_logs();
    repeat (3) send(32767);
    drain();
    for (int i = 0; i < log1.size(); i++) begin
      chk("satpos_data", log1[i], 32767);
      chk("satpos_flag", slog1[i], 1);
    end
    clear_logs();
    repeat (TAPS) send(-32768);
    drain();
    chk("satneg_count", log1.size(), TAPS);
    if (log1.size() > 0) begin
      chk("satneg_data", log1[log1.size()-1], -32768);
      chk("satneg_flag", slog1[slog1.size()-1], 1);
    end

    // Round half up at SHIFT=15.
    do_reset(2);
    write_coef(0, 16384);
    clear_logs();
    send(1);
    send(3);
    send(-1);
    drain();
    chk("round_count", log1.size(), 3);
    if (log1.size() == 3) begin
      chk("round_1", log1[0], 1);
      chk("round_3", log1[1], 2);
      chk("round_m1", log1[2], 0);
      chk("round_sat", slog1[0] + slog1[1] + slog1[2], 0);
    end
    if (log0.size() == 3) chk("round_raw_m1", log0[2], -16384);

    // Reset in the middle of a MAC sequence.
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    clear_logs();
    send(5);
    tick(9);
    do_reset(3);
    tick(TAPS + 4);
    chk("abort_no_strobe0", log0.size(), 0);
    chk("abort_no_strobe1", log1.size(), 0);
    send(1);
    drain();
    chk("abort_after_count", log0.size(), 1);
    if (log0.size() == 1) chk("abort_zero_coef0", log0[0], 0);
    if (log1.size() == 1) chk("abort_zero_coef1", log1[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule
